// File: rtl/wb_uart_pkg.sv
// Shared definitions for the Wishbone UART transmitter: register map, STATUS layout, shifter states.
package wb_uart_pkg;

  // Byte offsets of the registers relative to BASE_ADDR
  localparam logic [3:0] UART_DATA   = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_DIV    = 4'h8;
  localparam logic [3:0] UART_CTRL   = 4'hC;

  // STATUS bit positions
  localparam int unsigned ST_BUSY      = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_EMPTY     = 2;
  localparam int unsigned ST_OVF       = 3;
  localparam int unsigned ST_COUNT_LSB = 4;
  localparam int unsigned ST_COUNT_W   = 5;

  localparam int unsigned DIV_W   = 16;
  localparam logic [15:0] DIV_MIN = 16'd2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter; pop data and flags are combinational from the pointers.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 wdata,
  output logic [7:0]                 rdata_c,
  output logic                       full_c,
  output logic                       empty_c,
  output logic [$clog2(DEPTH):0]     count_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_tx_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    mem [DEPTH];
  logic          do_pop;
  logic          do_push;

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count_c = wr_ptr - rd_ptr;
  assign rdata_c = mem[rd_ptr[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands
  assign do_pop  = pop & ~empty_c;
  assign do_push = push & (~full_c | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone slave UART transmitter (8N1, LSB first) with TX FIFO and drain interrupt.
// Define WB_UART_TX_IRQ_EN to enable CTRL.irq_en and irq_o; otherwise irq_o is tied low.
module wb_uart_tx
  import wb_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1002_0000,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  // Bus side
  logic             ack_q;
  logic [31:0]      dat_q;
  logic             ovf_q;
  logic [DIV_W-1:0] div_q;
  logic             irq_en_q;
  logic             irq_en_d;
  logic             irq_q;
  logic             tx_q;

  logic             req_c;
  logic             hit_c;
  logic [3:0]       off_c;
  logic             wr_c;
  logic             push_req_c;
  logic             push_acc_c;
  logic             ovf_set_c;
  logic             ovf_clr_c;
  logic             div_wr_c;
  logic             ctrl_wr_c;
  logic [DIV_W-1:0] div_new_c;
  logic [31:0]      status_c;
  logic [31:0]      rdata_c;

  // FIFO
  logic             pop_c;
  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    count_next_c;

  // Shifter
  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] timer_q, timer_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [DIV_W-1:0] div_lat_q, div_lat_d;
  logic             tx_d;
  logic             busy_c;
  logic             irq_d;

  logic             unused_bus;
  assign unused_bus = ^{wb_adr_i[1:0], wb_sel_i[3:2], wb_dat_i[31:16]};

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign tx_o     = tx_q;
  assign irq_o    = irq_q;

  // Ack is one cycle wide; a request seen during the ack cycle is ignored
  assign req_c      = wb_cyc_i & wb_stb_i & ~ack_q;
  assign hit_c      = (wb_adr_i[31:4] == BASE_ADDR[31:4]);
  assign off_c      = {wb_adr_i[3:2], 2'b00};
  assign wr_c       = req_c & hit_c & wb_we_i;
  assign push_req_c = wr_c & (off_c == UART_DATA) & wb_sel_i[0];
  assign ovf_clr_c  = wr_c & (off_c == UART_STATUS) & wb_sel_i[0] & wb_dat_i[ST_OVF];
  assign div_wr_c   = wr_c & (off_c == UART_DIV) & (|wb_sel_i[1:0]);
  assign ctrl_wr_c  = wr_c & (off_c == UART_CTRL) & wb_sel_i[0];

  assign push_acc_c = push_req_c & (~fifo_full | pop_c);
  assign ovf_set_c  = push_req_c & fifo_full & ~pop_c;

  assign div_new_c = {wb_sel_i[1] ? wb_dat_i[15:8] : div_q[15:8],
                      wb_sel_i[0] ? wb_dat_i[7:0]  : div_q[7:0]};

`ifdef WB_UART_TX_IRQ_EN
  assign irq_en_d = ctrl_wr_c ? wb_dat_i[0] : irq_en_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) irq_en_q <= 1'b0;
    else          irq_en_q <= irq_en_d;
  end
`else
  logic unused_ctrl;
  assign unused_ctrl = ctrl_wr_c;
  assign irq_en_d    = 1'b0;
  assign irq_en_q    = 1'b0;
`endif

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .push    (push_req_c),
    .pop     (pop_c),
    .wdata   (wb_dat_i[7:0]),
    .rdata_c (fifo_rdata),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count_c (fifo_count)
  );

  assign busy_c = (state_q != TX_IDLE);

  always_comb begin
    status_c = '0;
    status_c[ST_BUSY]  = busy_c;
    status_c[ST_FULL]  = fifo_full;
    status_c[ST_EMPTY] = fifo_empty;
    status_c[ST_OVF]   = ovf_q;
    status_c[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
  end

  always_comb begin
    rdata_c = '0;
    if (hit_c) begin
      case (off_c)
        UART_STATUS: rdata_c = status_c;
        UART_DIV:    rdata_c = {16'h0000, div_q};
        UART_CTRL:   rdata_c = {31'h0, irq_en_q};
        default:     rdata_c = '0;
      endcase
    end
  end

  // Bus registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      ovf_q <= 1'b0;
      div_q <= DIV_RESET;
    end else begin
      ack_q <= req_c;
      dat_q <= req_c ? rdata_c : 32'h0;
      if (ovf_set_c)      ovf_q <= 1'b1;
      else if (ovf_clr_c) ovf_q <= 1'b0;
      if (div_wr_c) div_q <= (div_new_c < DIV_MIN) ? DIV_MIN : div_new_c;
    end
  end

  // Shifter next state; a frame's bit period is frozen at the pop
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    div_lat_d = div_lat_q;
    pop_c     = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop_c     = 1'b1;
          shreg_d   = fifo_rdata;
          div_lat_d = div_q;
          timer_d   = div_q - 16'd1;
          state_d   = TX_START;
        end
      end
      TX_START: begin
        if (timer_q == 16'd0) begin
          timer_d = div_lat_q - 16'd1;
          bit_d   = 3'd0;
          state_d = TX_DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (timer_q == 16'd0) begin
          timer_d = div_lat_q - 16'd1;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = TX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (timer_q == 16'd0) begin
          if (!fifo_empty) begin
            pop_c     = 1'b1;
            shreg_d   = fifo_rdata;
            div_lat_d = div_q;
            timer_d   = div_q - 16'd1;
            state_d   = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    if (state_q == TX_START)     tx_d = 1'b0;
    else if (state_q == TX_DATA) tx_d = shreg_q[0];
  end

  // Interrupt is registered from next-cycle values so it rises with the return to IDLE
  assign count_next_c = fifo_count + CW'(push_acc_c) - CW'(pop_c);
  assign irq_d        = irq_en_d & (count_next_c == '0) & (state_d == TX_IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= TX_IDLE;
      timer_q   <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      div_lat_q <= DIV_RESET;
      tx_q      <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      div_lat_q <= div_lat_d;
      tx_q      <= tx_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Self-checking bench for wb_uart_tx: directed bus steps plus random frames checked by a serial-line model.
module tb_wb_uart_tx;

  localparam logic [31:0] BASE = 32'h1002_0000;
  localparam int DEPTH = 16;
`ifdef WB_UART_TX_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i  = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        tx_o;
  logic        irq_o;

  wb_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd868)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (wb_rst_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .tx_o     (tx_o),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Serial-line reference: each expected frame is (byte, bit period)
  logic [7:0] exp_byte[$];
  int         exp_div[$];
  bit         mon_abort = 1'b1;
  bit         in_frame = 1'b0;
  int         pos = 0;
  logic [7:0] cur_b = '0;
  int         cur_d = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Frame position p maps to bit p/div: start(0), data LSB first, stop(9)
  task automatic mon_step();
    int  b;
    logic e;
    if (mon_abort) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (tx_o !== 1'b1) begin
        if (exp_byte.size() == 0) begin
          chk("tx_idle", {31'h0, tx_o}, 32'h1);
        end else begin
          cur_b    = exp_byte.pop_front();
          cur_d    = exp_div.pop_front();
          pos      = 1;
          in_frame = 1'b1;
        end
      end
    end else begin
      b = pos / cur_d;
      if (b == 0)      e = 1'b0;
      else if (b == 9) e = 1'b1;
      else             e = cur_b[b-1];
      chk("tx_bit", {31'h0, tx_o}, {31'h0, e});
      pos++;
      if (pos == 10 * cur_d) in_frame = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon_step();
  endtask

  // One bus transfer; returns at the negedge inside the ack cycle
  task automatic wb_xfer(input logic we, input logic [3:0] off, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd);
    tick();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = BASE | {28'h0, off}; wb_sel_i = sel; wb_dat_i = dat;
    tick();
    chk("ack", {31'h0, wb_ack_o}, 32'h1);
    rd = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] dat);
    logic [31:0] d;
    wb_xfer(1'b1, off, dat, 4'hF, d);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] d;
    wb_xfer(1'b0, off, 32'h0, 4'hF, d);
    chk(tag, d, exp);
  endtask

  task automatic push(input logic [7:0] b, input int d);
    wr(4'h0, {24'h0, b});
    exp_byte.push_back(b);
    exp_div.push_back(d);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_byte.size() != 0 || in_frame) && n < budget) begin
      tick();
      n++;
    end
    chk("drain", {31'h0, (exp_byte.size() == 0 && !in_frame)}, 32'h1);
  endtask

  function automatic logic [31:0] status_exp(input int cnt, input bit ovf, input bit busy);
    return (32'(cnt) << 4) | (32'(ovf) << 3) | (32'(cnt == DEPTH) << 1)
           | (32'(cnt == 0) << 2) | 32'(busy);
  endfunction

  initial begin
    int d;
    int n;
    int acc;
    logic [7:0] b;

    // Reset values
    repeat (3) tick();
    chk("rst_ack", {31'h0, wb_ack_o}, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_tx", {31'h0, tx_o}, 32'h1);
    chk("rst_irq", {31'h0, irq_o}, 32'h0);
    wb_rst_i = 1'b0;
    mon_abort = 1'b0;
    rd_chk("status0", 4'h4, 32'h4);
    rd_chk("div0", 4'h8, 32'd868);
    rd_chk("data_rd", 4'h0, 32'h0);

    // Ack never on back-to-back cycles with strobe held
    tick();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = BASE | 32'h8; wb_sel_i = 4'hF;
    tick(); chk("b2b_ack0", {31'h0, wb_ack_o}, 32'h1); chk("b2b_dat", wb_dat_o, 32'd868);
    tick(); chk("b2b_ack1", {31'h0, wb_ack_o}, 32'h0);
    tick(); chk("b2b_ack2", {31'h0, wb_ack_o}, 32'h1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;

    // Minimum divisor clamp
    wr(4'h8, 32'h0);  rd_chk("div_clamp0", 4'h8, 32'd2);
    wr(4'h8, 32'h1);  rd_chk("div_clamp1", 4'h8, 32'd2);

    // First-frame latency and busy flag
    wr(4'h8, 32'd4);
    push(8'h55, 4);
    tick(); chk("lat_hi", {31'h0, tx_o}, 32'h1);
    tick(); chk("lat_lo", {31'h0, tx_o}, 32'h0);
    rd_chk("status_busy", 4'h4, 32'h5);
    drain(100);
    rd_chk("status_idle", 4'h4, 32'h4);

    // DIV change mid-frame only affects the next frame
    push(8'hC3, 4);
    repeat (10) tick();
    wr(4'h8, 32'd7);
    push(8'h3C, 7);
    rd_chk("div_new", 4'h8, 32'd7);
    drain(300);

    // Overflow: one byte goes to the shifter, 16 fill the FIFO, the rest drop
    wr(4'h8, 32'd20);
    acc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      b = 8'($urandom);
      wr(4'h0, {24'h0, b});
      if (i == 0 || acc < DEPTH) begin
        if (i != 0) acc++;
        exp_byte.push_back(b);
        exp_div.push_back(20);
      end
    end
    rd_chk("status_ovf", 4'h4, status_exp(acc, 1'b1, 1'b1));
    wr(4'h4, 32'h0);
    rd_chk("ovf_keep", 4'h4, status_exp(acc, 1'b1, 1'b1));
    wr(4'h4, 32'h8);
    rd_chk("ovf_clr", 4'h4, status_exp(acc, 1'b0, 1'b1));
    drain(4000);
    rd_chk("status_drained", 4'h4, 32'h4);

    // Random bursts
    for (int r = 0; r < 6; r++) begin
      d = int'($urandom_range(2, 9));
      wr(4'h8, 32'(d));
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) begin
        push(8'($urandom), d);
        repeat ($urandom_range(0, 25)) tick();
      end
      drain(600);
    end
    rd_chk("status_rand", 4'h4, 32'h4);

    // Interrupt on drain
    wr(4'h8, 32'd3);
    wr(4'hC, 32'h1);
    chk("irq_en_idle", {31'h0, irq_o}, {31'h0, IRQ_BUILD});
    rd_chk("ctrl_rd", 4'hC, {31'h0, IRQ_BUILD});
    push(8'hA5, 3);
    for (int k = 0; k <= 33; k++) begin
      chk("irq_seq", {31'h0, irq_o}, {31'h0, IRQ_BUILD && k >= 31});
      tick();
    end
    drain(50);
    wr(4'hC, 32'h0);
    chk("irq_off", {31'h0, irq_o}, 32'h0);

    // Reset mid-DATA with three bytes queued
    wr(4'h8, 32'd10);
    for (int k = 0; k < 4; k++) push(8'($urandom), 10);
    repeat (25) tick();
    chk("mid_frame", {31'h0, in_frame}, 32'h1);
    mon_abort = 1'b1;
    exp_byte.delete();
    exp_div.delete();
    wb_rst_i = 1'b1;
    tick();
    chk("rst_mid_tx", {31'h0, tx_o}, 32'h1);
    wb_rst_i = 1'b0;
    mon_abort = 1'b0;
    rd_chk("rst_mid_status", 4'h4, 32'h4);
    rd_chk("rst_mid_div", 4'h8, 32'd868);
    repeat (400) tick();
    chk("rst_quiet", {31'h0, tx_o}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
